// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Holds on stall, loads a bubble on flush or invalid input, and counts bubbles with saturation.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] imm,
  input  logic             use_imm,
  input  logic [1:0]       ctrl_in,
  input  logic [RADDR-1:0] rs_in,
  input  logic [RADDR-1:0] rt_in,
  input  logic [RADDR-1:0] rd_in,
  input  logic             reg_write_in,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic             exmem_we,
  input  logic             memwb_we,
  input  logic [WIDTH-1:0] exmem_data,
  input  logic [WIDTH-1:0] memwb_data,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [1:0]       CTRL,
  output logic             valid_out,
  output logic             reg_write_out,
  output logic [RADDR-1:0] rd_out,
  output logic [15:0]      bubble_cnt
);

  logic [RADDR-1:0] src_addr [2];
  logic [WIDTH-1:0] src_data [2];
  logic [WIDTH-1:0] fwd_data [2];
  logic             bubble;
  logic [WIDTH-1:0] b_next;

  assign src_addr[0] = rs_in;
  assign src_addr[1] = rt_in;
  assign src_data[0] = rs_data;
  assign src_data[1] = rt_data;

  // EX/MEM wins over MEM/WB; register 0 is hard-wired and never forwarded.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_data[gi] =
        (exmem_we && (exmem_rd != '0) && (exmem_rd == src_addr[gi])) ? exmem_data :
        (memwb_we && (memwb_rd != '0) && (memwb_rd == src_addr[gi])) ? memwb_data :
        src_data[gi];
  end

  assign b_next = use_imm ? imm : fwd_data[1];

  // Flush beats stall; an invalid slot only becomes a bubble when the stage advances.
  assign bubble = flush | (~stall & ~valid_in);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      A             <= '0;
      B             <= '0;
      CTRL          <= '0;
      rd_out        <= '0;
      valid_out     <= 1'b0;
      reg_write_out <= 1'b0;
      bubble_cnt    <= '0;
    end else begin
      if (bubble) begin
        A             <= '0;
        B             <= '0;
        CTRL          <= '0;
        rd_out        <= '0;
        valid_out     <= 1'b0;
        reg_write_out <= 1'b0;
      end else if (!stall) begin
        A             <= fwd_data[0];
        B             <= b_next;
        CTRL          <= ctrl_in;
        rd_out        <= rd_in;
        valid_out     <= valid_in;
        reg_write_out <= reg_write_in & valid_in;
      end
      if (bubble && (bubble_cnt != 16'hFFFF))
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and model-checked random stimulus for id_ex_stage.
// One line per directed comparison; random-phase results appear only on mismatch.
module tb_id_ex_stage;
  localparam int WIDTH = 32;
  localparam int RADDR = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             valid_in, use_imm, reg_write_in, exmem_we, memwb_we, stall, flush;
  logic [WIDTH-1:0] rs_data, rt_data, imm, exmem_data, memwb_data;
  logic [1:0]       ctrl_in;
  logic [RADDR-1:0] rs_in, rt_in, rd_in, exmem_rd, memwb_rd;
  logic [WIDTH-1:0] A, B;
  logic [1:0]       CTRL;
  logic             valid_out, reg_write_out;
  logic [RADDR-1:0] rd_out;
  logic [15:0]      bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit verbose = 1'b1;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .rs_data(rs_data), .rt_data(rt_data),
    .imm(imm), .use_imm(use_imm), .ctrl_in(ctrl_in), .rs_in(rs_in), .rt_in(rt_in),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_we(exmem_we), .memwb_we(memwb_we), .exmem_data(exmem_data),
    .memwb_data(memwb_data), .stall(stall), .flush(flush), .A(A), .B(B), .CTRL(CTRL),
    .valid_out(valid_out), .reg_write_out(reg_write_out), .rd_out(rd_out),
    .bubble_cnt(bubble_cnt)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else if (verbose) begin
      $display("[TB] ok %s = %h", tag, got);
    end
  endtask

  function automatic logic [95:0] outs();
    return {7'd0, A, B, CTRL, valid_out, reg_write_out, rd_out, bubble_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_in = 0; use_imm = 0; reg_write_in = 0; exmem_we = 0; memwb_we = 0;
    stall = 0; flush = 0; rs_data = 0; rt_data = 0; imm = 0; exmem_data = 0;
    memwb_data = 0; ctrl_in = 0; rs_in = 0; rt_in = 0; rd_in = 0; exmem_rd = 0; memwb_rd = 0;
  endtask

  function automatic logic [WIDTH-1:0] ref_fwd(input logic [RADDR-1:0] src,
                                               input logic [WIDTH-1:0] rf);
    if (exmem_we && exmem_rd != 0 && exmem_rd == src) return exmem_data;
    if (memwb_we && memwb_rd != 0 && memwb_rd == src) return memwb_data;
    return rf;
  endfunction

  logic [WIDTH-1:0] e_a, e_b;
  logic [1:0]       e_ctrl;
  logic             e_v, e_rw, e_bub;
  logic [RADDR-1:0] e_rd;
  logic [15:0]      e_cnt, cnt_before;

  initial begin
    clear_inputs();
    #3;
    check("reset_outputs_zero", outs(), 96'd0);
    @(posedge clk); #1;
    reset = 1;

    // EX/MEM has priority when both downstream stages target rs
    valid_in = 1; reg_write_in = 1; rd_in = 9; ctrl_in = 2'b01;
    rs_in = 3; rs_data = 5; exmem_we = 1; exmem_rd = 3; exmem_data = 32'hAAAA0000;
    memwb_we = 1; memwb_rd = 3; memwb_data = 32'h1;
    tick();
    check("fwd_exmem_priority_A", A, 32'hAAAA0000);
    check("capture_valid_rw_rd", {valid_out, reg_write_out, rd_out}, {1'b1, 1'b1, 5'd9});
    check("capture_ctrl", CTRL, 2'b01);

    exmem_we = 0;
    tick();
    check("fwd_memwb_A", A, 32'h1);

    exmem_we = 1; exmem_rd = 4;
    tick();
    check("fwd_exmem_other_reg_A", A, 32'h1);

    rs_in = 0; rs_data = 32'h12; exmem_rd = 0; exmem_data = 32'hFFFFFFFF; memwb_rd = 0;
    tick();
    check("no_fwd_reg0_A", A, 32'h12);

    // immediate overrides a forwarded rt
    use_imm = 1; imm = 32'hFFFFFFF0; rt_in = 4; rt_data = 32'h33;
    exmem_rd = 4; exmem_data = 32'hDEAD0004; ctrl_in = 2'b10;
    tick();
    check("imm_B", B, 32'hFFFFFFF0);
    check("imm_ctrl", CTRL, 2'b10);

    use_imm = 0;
    tick();
    check("fwd_exmem_B", B, 32'hDEAD0004);

    exmem_we = 0; memwb_we = 0;
    tick();
    check("rf_B", B, 32'h33);

    valid_in = 0; reg_write_in = 1;
    tick();
    check("invalid_bubble", outs(), {7'd0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 5'd0, 16'd1});

    // stall holds the captured instruction and never counts as a bubble
    valid_in = 1; rs_in = 1; rs_data = 7; rd_in = 6; ctrl_in = 2'b11;
    tick();
    check("capture_A7", A, 32'd7);
    cnt_before = bubble_cnt;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rs_data = 32'h100 + i; rd_in = 5'(i + 10); exmem_we = 1; exmem_rd = 1;
      exmem_data = 32'hBEEF;
      valid_in = (i != 1);
      tick();
    end
    check("stall_hold_A", A, 32'd7);
    check("stall_hold_rd_valid", {rd_out, valid_out, CTRL}, {5'd6, 1'b1, 2'b11});
    check("stall_cnt_unchanged", bubble_cnt, cnt_before);

    flush = 1;
    tick();
    check("stall_flush_bubble", {A, valid_out, rd_out}, {32'd0, 1'b0, 5'd0});
    check("stall_flush_cnt", bubble_cnt, cnt_before + 16'd1);

    // asynchronous reset between edges, held through stall+flush
    stall = 0; flush = 0; exmem_we = 0; valid_in = 1; rs_data = 32'h55;
    tick();
    check("pre_reset_valid", valid_out, 1'b1);
    #2 reset = 0;
    #1 check("async_reset_zero", outs(), 96'd0);
    stall = 1; flush = 1;
    tick();
    check("reset_overrides_flush", outs(), 96'd0);
    reset = 1; stall = 0; flush = 0; valid_in = 1; rs_data = 32'h77; rd_in = 3;
    tick();
    check("post_reset_capture", {A, valid_out, rd_out, bubble_cnt},
          {32'h77, 1'b1, 5'd3, 16'd0});

    // random stimulus against a reference model
    verbose = 0;
    e_a = A; e_b = B; e_ctrl = CTRL; e_v = valid_out; e_rw = reg_write_out;
    e_rd = rd_out; e_cnt = bubble_cnt;
    for (int i = 0; i < 1000; i++) begin
      valid_in = ($urandom_range(0, 3) != 0); use_imm = $urandom_range(0, 1);
      reg_write_in = $urandom_range(0, 1); exmem_we = $urandom_range(0, 1);
      memwb_we = $urandom_range(0, 1); stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      rs_data = $urandom; rt_data = $urandom; imm = $urandom;
      exmem_data = $urandom; memwb_data = $urandom; ctrl_in = 2'($urandom);
      rs_in = 5'($urandom_range(0, 3)); rt_in = 5'($urandom_range(0, 3));
      rd_in = 5'($urandom); exmem_rd = 5'($urandom_range(0, 3));
      memwb_rd = 5'($urandom_range(0, 3));
      e_bub = flush || (!stall && !valid_in);
      if (e_bub) begin
        e_a = 0; e_b = 0; e_ctrl = 0; e_rd = 0; e_v = 0; e_rw = 0;
      end else if (!stall) begin
        e_a = ref_fwd(rs_in, rs_data);
        e_b = use_imm ? imm : ref_fwd(rt_in, rt_data);
        e_ctrl = ctrl_in; e_rd = rd_in; e_v = valid_in; e_rw = reg_write_in && valid_in;
      end
      if (e_bub && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
      tick();
      check($sformatf("rnd_%0d", i), outs(), {7'd0, e_a, e_b, e_ctrl, e_v, e_rw, e_rd, e_cnt});
    end
    verbose = 1;

    // bubble counter saturation
    clear_inputs();
    reset = 0;
    #2 reset = 1;
    flush = 1;
    repeat (65534) tick();
    check("cnt_FFFE", bubble_cnt, 16'hFFFE);
    tick();
    check("cnt_FFFF", bubble_cnt, 16'hFFFF);
    tick();
    check("cnt_saturate", bubble_cnt, 16'hFFFF);
    flush = 0; valid_in = 0;
    tick();
    check("cnt_saturate_invalid", bubble_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
